wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback-stage receiver for the EX/WB pipeline register outputs (alu/sfu/bru/agu result channels).
- Merges up to four results per cycle onto NPORTS physical-register-file write ports. Results that do not fit are buffered in a result FIFO.
- Drives the EX/WB stall input back upstream.
- Converts BRU results into a one-cycle recover pulse, a redirect PC and a branch-predictor update.

Parameters:
- NPORTS, 2, number of PRF write ports (1..4).
- DEPTH, 8, result FIFO entries (power of two, >= 4).
- PRW, 6, physical register number width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- aluoutw/alurdw/aluenw  in  32/PRW/1  ALU result, dest, valid.
- sfuoutw/sfurdw/sfuenw  in  32/PRW/1  SFU result, dest, valid.
- aguoutw/agurdw/aguenw  in  32/PRW/1  AGU result, dest, valid.
- pre_rightw  in  1  BRU prediction correct.
- b_typew  in  1  BRU instruction is B-type (no rd write).
- real_directionw  in  1  actual branch direction.
- addrw  in  32  actual target address.
- brurdw  in  PRW  BRU destination (link register).
- bruenw  in  1  BRU result valid.
- wb_we  out  NPORTS  per-port PRF write enable.
- wb_waddr  out  PRW*NPORTS  port k at bits [PRW*k +: PRW].
- wb_wdata  out  32*NPORTS  port k at bits [32*k +: 32]; BRU data is the link value on aluout-style data (addrw is not written).
- stall  out  1  drives EX/WB stall (hold).
- recover  out  1  one-cycle mispredict pulse; drives EX/WB recover.
- redirect_pc  out  32  fetch redirect target, valid with recover.
- bp_valid  out  1  predictor-update strobe.
- bp_taken  out  1  actual direction.
- bp_btype  out  1  B-type flag.
- bp_target  out  32  actual target.

BRU link-data input:
- The BRU data path uses input bru_link, 32 bits, carrying the link value.

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty (rd/wr pointers and count 0). This also applies mid-operation: buffered entries are discarded.

Acceptance:
- Inputs are accepted in a cycle iff stall==0. While stall==1, all input channels are ignored; EX/WB holds them and re-presents them.

Write requests:
- Requests come from aluen, sfuen, aguen, and (bruen & ~b_typew).
- A request with rd==0 is dropped: no write, no enqueue.

Slot selection (combinational, per cycle):
- Candidates are ordered: FIFO entries from head (oldest first), then accepted inputs in fixed order alu, sfu, bru, agu.
- The first NPORTS candidates are assigned to ports 0..NPORTS-1 in that order.
- Remaining accepted inputs are enqueued in the same order (up to 4 per cycle).
- FIFO entries never bypass each other.

Latency and ordering:
- Write ports are registered. An input accepted in cycle t with an empty FIFO and at most NPORTS requests appears on wb_* in cycle t+1.
- Unused ports have wb_we=0, and waddr/wdata are 0.
- No rd hazards: physical destinations are unique, so no data ordering check is needed.

Count and stall:
- count_next = count + enq - deq, where deq = min(count, NPORTS).
- stall is registered: stall <= (DEPTH - count_next) < 4.
- Consequences:
  - Overflow cannot occur, because an accepting cycle always has >= 4 free entries.
  - During stall, only draining occurs.
  - stall drops the cycle after free entries are >= 4.

Branch handling (on an accepted bruen):
- bp_valid <= 1 for one cycle, with bp_taken/bp_btype/bp_target registered from real_directionw/b_typew/addrw.
- If pre_rightw==0: recover <= 1 for one cycle and redirect_pc <= addrw. Otherwise recover <= 0.
- The FIFO is not flushed on recover; the rename/freelist recovery owns wrong-path cleanup.
- The BRU link write, if any, proceeds normally.
- A second mispredict cannot arrive the cycle after recover, because EX/WB is cleared by recover.

Simultaneous events:
- rst dominates everything.
- Enqueue and dequeue in the same cycle are both applied.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- Macro: WB_ARB_PERF_EN.
- Defined: adds outputs perf_branches (32), perf_mispredicts (32) and perf_stall_cycles (32).
  - Reset to 0.
  - perf_branches increments on each bp_valid; perf_mispredicts on each recover; perf_stall_cycles on each cycle with stall==1.
  - All counters wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single ALU result: aluenw=1, alurdw=5, aluoutw=0xDEADBEEF, FIFO empty -> next cycle wb_we=2'b01, port0 addr 5 and data 0xDEADBEEF. No enqueue, stall stays 0.
- Four results in one cycle: alu rd1, sfu rd2, bru rd3 (b_type=0), agu rd4 -> cycle t+1 writes rd1/rd2, cycle t+2 writes rd3/rd4 (from the FIFO). No inputs in t+1 -> count returns to 0.
- Back-to-back 4-result cycles with DEPTH=8 -> stall rises when free < 4. During stall, fresh input values are ignored and held values are consumed exactly once after stall drops. Every rd (unique per cycle) is written exactly once, in order.
- Mispredict: bruenw=1, pre_rightw=0, b_typew=1, real_directionw=1, addrw=0x80001000 -> next cycle recover=1 for exactly 1 cycle, redirect_pc=0x80001000, bp_valid=1, bp_taken=1. No PRF write.
- Correct JAL: bruenw=1, pre_rightw=1, b_typew=0, brurdw=9, bru_link=0x80000008 -> recover stays 0, bp_valid=1, and port0 writes rd9=0x80000008. With rd=0 the same stimulus gives no write.
- Asynchronous rst asserted mid-cycle with 5 FIFO entries and stall=1 -> all outputs 0 immediately, count 0. After release, the first accepted ALU result is written the next cycle. Perf counters are 0 when WB_ARB_PERF_EN is defined.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU/SFU/BRU/AGU results onto NPORTS PRF write ports through an overflow FIFO.
// Optional performance counters are enabled with `define WB_ARB_PERF_EN.
module wb_arbiter #(
  parameter int NPORTS = 2,
  parameter int DEPTH  = 8,
  parameter int PRW    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           aluoutw,
  input  logic [PRW-1:0]        alurdw,
  input  logic                  aluenw,
  input  logic [31:0]           sfuoutw,
  input  logic [PRW-1:0]        sfurdw,
  input  logic                  sfuenw,
  input  logic [31:0]           aguoutw,
  input  logic [PRW-1:0]        agurdw,
  input  logic                  aguenw,
  input  logic                  pre_rightw,
  input  logic                  b_typew,
  input  logic                  real_directionw,
  input  logic [31:0]           addrw,
  input  logic [PRW-1:0]        brurdw,
  input  logic                  bruenw,
  input  logic [31:0]           bru_link,
  output logic [NPORTS-1:0]     wb_we,
  output logic [PRW*NPORTS-1:0] wb_waddr,
  output logic [32*NPORTS-1:0]  wb_wdata,
  output logic                  stall,
  output logic                  recover,
  output logic [31:0]           redirect_pc,
  output logic                  bp_valid,
  output logic                  bp_taken,
  output logic                  bp_btype,
  output logic [31:0]           bp_target
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]           perf_branches,
  output logic [31:0]           perf_mispredicts,
  output logic [31:0]           perf_stall_cycles
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PRW + 32;

  logic [EW-1:0]          mem_q [DEPTH];
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d, deq;
  logic                   stall_q, stall_d;
  logic [3:0]             deq4;
  logic [3:0]             req;
  logic [EW-1:0]          req_ent [4];
  logic [3:0]             pos [4];
  logic [3:0]             enq_v;
  logic [EW-1:0]          enq_ent [4];
  logic [2:0]             enq_n;
  logic [NPORTS-1:0]      we_q, we_d;
  logic [PRW*NPORTS-1:0]  waddr_q, waddr_d;
  logic [32*NPORTS-1:0]   wdata_q, wdata_d;
  logic                   accept, bru_acc;
  logic                   recover_q, bp_valid_q, bp_taken_q, bp_btype_q;
  logic [31:0]            redirect_q, bp_target_q;

  assign accept  = ~stall_q;
  assign bru_acc = accept & bruenw;

  // Requests in fixed priority order alu, sfu, bru, agu; rd==0 never writes.
  assign req[0] = accept & aluenw & (alurdw != '0);
  assign req[1] = accept & sfuenw & (sfurdw != '0);
  assign req[2] = bru_acc & ~b_typew & (brurdw != '0);
  assign req[3] = accept & aguenw & (agurdw != '0);
  assign req_ent[0] = {alurdw, aluoutw};
  assign req_ent[1] = {sfurdw, sfuoutw};
  assign req_ent[2] = {brurdw, bru_link};
  assign req_ent[3] = {agurdw, aguoutw};

  assign deq  = (count_q < CW'(NPORTS)) ? count_q : CW'(NPORTS);
  assign deq4 = 4'(deq);

  // Candidate position of each request behind the dequeued FIFO entries.
  always_comb begin
    pos[0] = deq4;
    for (int j = 1; j < 4; j++) pos[j] = pos[j-1] + {3'b000, req[j-1]};
  end

  always_comb begin
    we_d    = '0;
    waddr_d = '0;
    wdata_d = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (4'(p) < deq4) begin
        we_d[p] = 1'b1;
        {waddr_d[p*PRW +: PRW], wdata_d[p*32 +: 32]} = mem_q[rd_ptr_q + PW'(p)];
      end
      for (int j = 0; j < 4; j++) begin
        if (req[j] && (pos[j] == 4'(p))) begin
          we_d[p] = 1'b1;
          {waddr_d[p*PRW +: PRW], wdata_d[p*32 +: 32]} = req_ent[j];
        end
      end
    end
    enq_v = '0;
    enq_n = '0;
    for (int k = 0; k < 4; k++) begin
      enq_ent[k] = '0;
      for (int j = 0; j < 4; j++) begin
        if (req[j] && (pos[j] == 4'(NPORTS + k))) begin
          enq_v[k]   = 1'b1;
          enq_ent[k] = req_ent[j];
        end
      end
      enq_n = enq_n + {2'b00, enq_v[k]};
    end
  end

  // An accepting cycle always sees at least four free entries, so no overflow check is needed.
  always_comb begin
    count_d  = count_q + CW'(enq_n) - deq;
    rd_ptr_d = rd_ptr_q + PW'(deq);
    wr_ptr_d = wr_ptr_q + PW'(enq_n);
    stall_d  = (CW'(DEPTH) - count_d) < CW'(4);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (enq_v[k]) mem_q[wr_ptr_q + PW'(k)] <= enq_ent[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      stall_q     <= 1'b0;
      we_q        <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      recover_q   <= 1'b0;
      redirect_q  <= '0;
      bp_valid_q  <= 1'b0;
      bp_taken_q  <= 1'b0;
      bp_btype_q  <= 1'b0;
      bp_target_q <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      stall_q    <= stall_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      bp_valid_q <= bru_acc;
      recover_q  <= bru_acc & ~pre_rightw;
      if (bru_acc) begin
        bp_taken_q  <= real_directionw;
        bp_btype_q  <= b_typew;
        bp_target_q <= addrw;
      end
      if (bru_acc & ~pre_rightw) redirect_q <= addrw;
    end
  end

  assign wb_we       = we_q;
  assign wb_waddr    = waddr_q;
  assign wb_wdata    = wdata_q;
  assign stall       = stall_q;
  assign recover     = recover_q;
  assign redirect_pc = redirect_q;
  assign bp_valid    = bp_valid_q;
  assign bp_taken    = bp_taken_q;
  assign bp_btype    = bp_btype_q;
  assign bp_target   = bp_target_q;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_br_q, perf_mp_q, perf_st_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
      perf_st_q <= '0;
    end else begin
      if (bp_valid_q) perf_br_q <= perf_br_q + 32'd1;
      if (recover_q)  perf_mp_q <= perf_mp_q + 32'd1;
      if (stall_q)    perf_st_q <= perf_st_q + 32'd1;
    end
  end

  assign perf_branches     = perf_br_q;
  assign perf_mispredicts  = perf_mp_q;
  assign perf_stall_cycles = perf_st_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter: a queue-based model predicts writes, stall and branch updates.
module tb_wb_arbiter;
  localparam int NPORTS = 2;
  localparam int DEPTH  = 8;
  localparam int PRW    = 6;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] aluoutw, sfuoutw, aguoutw, addrw, bru_link;
  logic [PRW-1:0] alurdw, sfurdw, agurdw, brurdw;
  logic aluenw, sfuenw, aguenw, pre_rightw, b_typew, real_directionw, bruenw;
  logic [NPORTS-1:0] wb_we;
  logic [PRW*NPORTS-1:0] wb_waddr;
  logic [32*NPORTS-1:0] wb_wdata;
  logic stall, recover, bp_valid, bp_taken, bp_btype;
  logic [31:0] redirect_pc, bp_target;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_branches, perf_mispredicts, perf_stall_cycles;
`endif

  wb_arbiter #(.NPORTS(NPORTS), .DEPTH(DEPTH), .PRW(PRW)) dut (
    .clk(clk), .rst(rst),
    .aluoutw(aluoutw), .alurdw(alurdw), .aluenw(aluenw),
    .sfuoutw(sfuoutw), .sfurdw(sfurdw), .sfuenw(sfuenw),
    .aguoutw(aguoutw), .agurdw(agurdw), .aguenw(aguenw),
    .pre_rightw(pre_rightw), .b_typew(b_typew), .real_directionw(real_directionw),
    .addrw(addrw), .brurdw(brurdw), .bruenw(bruenw), .bru_link(bru_link),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stall(stall), .recover(recover), .redirect_pc(redirect_pc),
    .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_btype(bp_btype), .bp_target(bp_target)
`ifdef WB_ARB_PERF_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [PRW-1:0] rd; logic [31:0] data; } wr_t;
  typedef struct packed { logic stall; logic [2:0] nwr; logic bpv; logic rec; } cyc_t;
  typedef struct packed { logic taken; logic btype; logic [31:0] target; } bp_t;
  typedef struct {
    logic aen, sen, ben, gen;
    logic [PRW-1:0] ard, srd, brd, grd;
    logic [31:0] ad, sd, gd, link, addr;
    logic pr, bt, dir;
  } in_t;

  wr_t  mq[$];
  wr_t  exp_wr[$];
  cyc_t exp_cyc[$];
  bp_t  exp_bp[$];
  bit   m_stall = 1'b0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic in_t idle();
    in_t t = '{default: '0};
    return t;
  endfunction

  function automatic in_t rand_txn();
    in_t t;
    t.aen = ($urandom_range(0, 5) != 0);
    t.sen = ($urandom_range(0, 5) != 0);
    t.ben = ($urandom_range(0, 3) == 0);
    t.gen = ($urandom_range(0, 5) != 0);
    t.ard = PRW'($urandom_range(0, 63));
    t.srd = PRW'($urandom_range(0, 63));
    t.brd = PRW'($urandom_range(0, 63));
    t.grd = PRW'($urandom_range(0, 63));
    t.ad = $urandom(); t.sd = $urandom(); t.gd = $urandom();
    t.link = $urandom(); t.addr = $urandom();
    t.pr = 1'($urandom_range(0, 1));
    t.bt = 1'($urandom_range(0, 1));
    t.dir = 1'($urandom_range(0, 1));
    return t;
  endfunction

  function automatic in_t quad(input int base, input bit with_agu);
    in_t t = idle();
    t.aen = 1'b1; t.sen = 1'b1; t.ben = 1'b1; t.gen = with_agu;
    t.ard = PRW'(base); t.srd = PRW'(base + 1); t.brd = PRW'(base + 2); t.grd = PRW'(base + 3);
    t.ad = 32'hA000_0000 + 32'(base); t.sd = 32'hB000_0000 + 32'(base);
    t.link = 32'hC000_0000 + 32'(base); t.gd = 32'hD000_0000 + 32'(base);
    t.pr = 1'b1; t.bt = 1'b0; t.dir = 1'b1; t.addr = 32'h1000 + 32'(base);
    return t;
  endfunction

  task automatic apply(input in_t t);
    aluenw = t.aen; alurdw = t.ard; aluoutw = t.ad;
    sfuenw = t.sen; sfurdw = t.srd; sfuoutw = t.sd;
    aguenw = t.gen; agurdw = t.grd; aguoutw = t.gd;
    bruenw = t.ben; brurdw = t.brd; bru_link = t.link;
    pre_rightw = t.pr; b_typew = t.bt; real_directionw = t.dir; addrw = t.addr;
  endtask

  function automatic void mpush(input logic [PRW-1:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd;
    w.data = data;
    mq.push_back(w);
  endfunction

  // Reference model: accepted requests join the pending list; the oldest NPORTS leave each cycle.
  task automatic drive(input in_t t);
    cyc_t c;
    bp_t b;
    int n;
    @(negedge clk);
    apply(t);
    if (!m_stall) begin
      if (t.aen && t.ard != 0) mpush(t.ard, t.ad);
      if (t.sen && t.srd != 0) mpush(t.srd, t.sd);
      if (t.ben && !t.bt && t.brd != 0) mpush(t.brd, t.link);
      if (t.gen && t.grd != 0) mpush(t.grd, t.gd);
    end
    n = (mq.size() < NPORTS) ? mq.size() : NPORTS;
    for (int i = 0; i < n; i++) exp_wr.push_back(mq.pop_front());
    c.stall = (DEPTH - mq.size()) < 4;
    c.nwr   = 3'(n);
    c.bpv   = !m_stall && t.ben;
    c.rec   = c.bpv && !t.pr;
    exp_cyc.push_back(c);
    if (c.bpv) begin
      b.taken = t.dir;
      b.btype = t.bt;
      b.target = t.addr;
      exp_bp.push_back(b);
    end
    m_stall = c.stall;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"}, 64'(wb_we), 64'(0));
    chk({tag, "_waddr"}, 64'(wb_waddr), 64'(0));
    chk({tag, "_wdata"}, 64'(wb_wdata), 64'(0));
    chk({tag, "_stall"}, 64'(stall), 64'(0));
    chk({tag, "_recover"}, 64'(recover), 64'(0));
    chk({tag, "_redirect"}, 64'(redirect_pc), 64'(0));
    chk({tag, "_bpv"}, 64'(bp_valid), 64'(0));
    chk({tag, "_bptaken"}, 64'(bp_taken), 64'(0));
    chk({tag, "_bpbtype"}, 64'(bp_btype), 64'(0));
    chk({tag, "_bptarget"}, 64'(bp_target), 64'(0));
`ifdef WB_ARB_PERF_EN
    chk({tag, "_perf_br"}, 64'(perf_branches), 64'(0));
    chk({tag, "_perf_mp"}, 64'(perf_mispredicts), 64'(0));
    chk({tag, "_perf_st"}, 64'(perf_stall_cycles), 64'(0));
`endif
  endtask

  // Monitor: samples one time unit after each rising edge.
  initial begin
    forever begin
      cyc_t c;
      wr_t w;
      bp_t b;
      int nw;
      logic [NPORTS:0] wm;
      @(posedge clk);
      #1;
      nw = 0;
      for (int p = 0; p < NPORTS; p++) nw += int'(wb_we[p]);
      if (exp_cyc.size() > 0) begin
        c = exp_cyc.pop_front();
        chk("stall", 64'(stall), 64'(c.stall));
        chk("nwrites", 64'(nw), 64'(c.nwr));
        chk("bp_valid", 64'(bp_valid), 64'(c.bpv));
        chk("recover", 64'(recover), 64'(c.rec));
      end
      wm = {1'b0, wb_we};
      chk("we_contiguous", 64'((wm + 1'b1) & wm), 64'(0));
      for (int p = 0; p < NPORTS; p++) begin
        if (wb_we[p]) begin
          if (exp_wr.size() == 0) begin
            chk("unexpected_write", 64'(wb_waddr[p*PRW +: PRW]), 64'(0));
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 64'(wb_waddr[p*PRW +: PRW]), 64'(w.rd));
            chk("wr_data", 64'(wb_wdata[p*32 +: 32]), 64'(w.data));
          end
        end else begin
          chk("idle_port", {26'(wb_waddr[p*PRW +: PRW]), wb_wdata[p*32 +: 32]}, 64'(0));
        end
      end
      if (bp_valid) begin
        if (exp_bp.size() == 0) begin
          chk("unexpected_bp", 64'(bp_valid), 64'(0));
        end else begin
          b = exp_bp.pop_front();
          chk("bp_taken", 64'(bp_taken), 64'(b.taken));
          chk("bp_btype", 64'(bp_btype), 64'(b.btype));
          chk("bp_target", 64'(bp_target), 64'(b.target));
          if (recover) chk("redirect_pc", 64'(redirect_pc), 64'(b.target));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t t, pend;
    apply(idle());
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    t = idle(); t.aen = 1'b1; t.ard = 6'd5; t.ad = 32'hDEADBEEF;
    drive(t);
    drive(idle());
    drive(quad(1, 1'b1));
    drive(idle());
    drive(idle());

    t = idle(); t.ben = 1'b1; t.pr = 1'b0; t.bt = 1'b1; t.dir = 1'b1;
    t.addr = 32'h80001000; t.brd = 6'd12;
    drive(t);
    drive(idle());
    drive(idle());

    t = idle(); t.ben = 1'b1; t.pr = 1'b1; t.bt = 1'b0; t.brd = 6'd9;
    t.link = 32'h80000008; t.addr = 32'h80000100;
    drive(t);
    t.brd = '0;
    drive(t);
    drive(idle());

    pend = rand_txn();
    for (int i = 0; i < 300; i++) begin
      if (m_stall) drive(rand_txn());
      else begin
        drive(pend);
        pend = rand_txn();
      end
      if (i % 40 == 0) begin
        drive(quad(10, 1'b1));
        drive(quad(20, 1'b1));
        drive(quad(30, 1'b1));
      end
    end
    for (int i = 0; i < 40 && (mq.size() > 0 || m_stall); i++) drive(idle());
    drive(idle());
    drive(idle());

    drive(quad(40, 1'b1));
    drive(quad(44, 1'b1));
    drive(quad(48, 1'b0));
    @(negedge clk);
    chk("pre_reset_stall", 64'(stall), 64'(1));
    apply(idle());
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    mq.delete();
    exp_wr.delete();
    exp_cyc.delete();
    exp_bp.delete();
    m_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    t = idle(); t.aen = 1'b1; t.ard = 6'd33; t.ad = 32'h12345678;
    drive(t);
    drive(idle());
    drive(idle());
    @(posedge clk);
    #2;
    chk("left_writes", 64'(exp_wr.size()), 64'(0));
    chk("left_cycles", 64'(exp_cyc.size()), 64'(0));
    chk("left_bp", 64'(exp_bp.size()), 64'(0));
    chk("left_model", 64'(mq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
